sequence_generator: RTL

Serial frame transmitter that produces the bit stream consumed by the overlapping `1011` sequence detector. It accepts a parallel payload word over a valid/ready handshake and emits a frame one bit per clock: a fixed `SYNC_LEN`-bit sync header, then the payload MSB-first, then an idle gap. It serves as the stimulus source and link partner for the detector in loop-back benches and in the top-level serial path.

---
 rtl/seq_pkg.sv | 25 ++
 rtl/piso_shift.sv | 29 ++
 rtl/sequence_generator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial frame generator and its detector partner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        GAP  = 3'd3
    } seqgen_state_t;

    localparam logic [3:0] SEQ_SYNC_1011 = 4'b1011;

    // Span the bit counter must cover; floor of 2 keeps the counter at least 1 bit wide.
    function automatic int cnt_span(input int width, input int sync_len, input int gap_cycles);
        int m;
        m = 2;
        if (width > m) m = width;
        if (sync_len > m) m = sync_len;
        if (gap_cycles > m) m = gap_cycles;
        return m;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, MSB-first shift register; msb reflects the current top bit.
// Latency: load or shift takes effect on the next rising edge.
// Backpressure: none; load wins over shift.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q << 1;
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial frame transmitter: sync header, payload MSB-first, then an idle gap.
// Latency: first sync bit on seq_out the cycle after the data_valid/data_ready handshake.
// Backpressure: data_ready is high only in IDLE; one word per 1+SYNC_LEN+WIDTH+GAP_CYCLES cycles.
module sequence_generator import seq_pkg::*; #(
    parameter int                  WIDTH        = 8,
    parameter int                  SYNC_LEN     = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SEQ_SYNC_1011,
    parameter int                  GAP_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(cnt_span(WIDTH, SYNC_LEN, GAP_CYCLES));
    localparam logic [CW-1:0] LAST_SYNC     = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] LAST_DATA     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST_DATA = CW'(WIDTH - 2);
    localparam logic [CW-1:0] LAST_GAP      = CW'(GAP_CYCLES - 1);

    seqgen_state_t state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          sync_msb;
    logic          pay_msb;
    logic          sync_shift;
    logic          pay_shift;

    assign data_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = data_ready && data_valid;
    assign sync_shift = (state == SYNC);
    assign pay_shift  = ((state == SYNC) && (cnt == LAST_SYNC)) || (state == DATA);

    // seq_out is registered, so each edge loads the bit for the following cycle.
    // The sync MSB goes straight to seq_out at the handshake, hence the pre-shifted load.
    piso_shift #(.WIDTH(SYNC_LEN)) u_sync_sr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (sync_shift),
        .din   (SYNC_PATTERN << 1),
        .msb   (sync_msb)
    );

    piso_shift #(.WIDTH(WIDTH)) u_payload_sr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (pay_shift),
        .din   (data_in),
        .msb   (pay_msb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            seq_out    <= 1'b0;
            seq_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    cnt        <= '0;
                    if (accept) begin
                        state     <= SYNC;
                        seq_out   <= SYNC_PATTERN[SYNC_LEN-1];
                        seq_valid <= 1'b1;
                    end else begin
                        seq_out   <= 1'b0;
                        seq_valid <= 1'b0;
                    end
                end
                SYNC: begin
                    if (cnt == LAST_SYNC) begin
                        state      <= DATA;
                        cnt        <= '0;
                        seq_out    <= pay_msb;
                        frame_done <= (WIDTH == 1);
                    end else begin
                        cnt     <= cnt + CW'(1);
                        seq_out <= sync_msb;
                    end
                end
                DATA: begin
                    if (cnt == LAST_DATA) begin
                        state      <= (GAP_CYCLES == 0) ? IDLE : GAP;
                        cnt        <= '0;
                        seq_out    <= 1'b0;
                        seq_valid  <= 1'b0;
                        frame_done <= 1'b0;
                    end else begin
                        cnt        <= cnt + CW'(1);
                        seq_out    <= pay_msb;
                        frame_done <= (WIDTH > 1) && (cnt == PRE_LAST_DATA);
                    end
                end
                GAP: begin
                    if (cnt == LAST_GAP) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    seq_out    <= 1'b0;
                    seq_valid  <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
